dram_ctrl: RTL and testbench



---
 rtl/dram_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dram_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// dram_ctrl: turns single-word read/write requests into RAS/CAS/RD/WR strobe sequences for a DRAM primitive.
// Define DRAM_CTRL_REFRESH_EN to compile in periodic CAS-before-RAS refresh.
module dram_ctrl #(
  parameter int DW         = 8,
  parameter int RW         = 8,
  parameter int CW         = 8,
  parameter int REF_PERIOD = 512
) (
  input  logic             i_MCLK,
  input  logic             i_RST,
  input  logic             i_REQ,
  input  logic             i_WE,
  input  logic [RW+CW-1:0] i_ADDR,
  input  logic [DW-1:0]    i_WDATA,
  output logic             o_READY,
  output logic [DW-1:0]    o_RDATA,
  output logic             o_RVALID,
  output logic [RW-1:0]    o_DRAM_ADDR,
  output logic [DW-1:0]    o_DRAM_DIN,
  input  logic [DW-1:0]    i_DRAM_DOUT,
  output logic             o_RAS_n,
  output logic             o_CAS_n,
  output logic             o_WR_n,
  output logic             o_RD_n,
  output logic [2:0]       o_DBG_STATE
);

`ifdef DRAM_CTRL_REFRESH_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RAS, S_CAS, S_ACC, S_PRE, S_REF_CAS, S_REF_RAS, S_REF_PRE
  } state_t;
  localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
  logic           ref_pend_q, ref_pend_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_RAS, S_CAS, S_ACC, S_PRE} state_t;
  logic unused_ref_period;
  assign unused_ref_period = (REF_PERIOD > 0);
`endif

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] addr_q, addr_d, col_ext;
  logic [DW-1:0] din_q, din_d, rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d, ready_q, ready_d;
  logic          ras_n_q, ras_n_d, cas_n_q, cas_n_d;
  logic          wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic          accept;

  // Request handshake: a request transfers on a rising edge where i_REQ=1 and
  // o_READY=1; i_WE/i_ADDR/i_WDATA are sampled on that edge only, and i_REQ in
  // any other cycle is ignored (nothing is queued).
  assign accept = (state_q == S_IDLE) && ready_q && i_REQ;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    col_d    = col_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
`ifdef DRAM_CTRL_REFRESH_EN
    ref_pend_d = ref_pend_q;
    ref_cnt_d  = (ref_cnt_q == RCW'(REF_PERIOD - 1)) ? '0 : ref_cnt_q + 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef DRAM_CTRL_REFRESH_EN
        if (ref_pend_q) begin
          state_d    = S_REF_CAS;
          ref_pend_d = 1'b0;
        end else
`endif
        if (accept) begin
          state_d = S_RAS;
          we_d    = i_WE;
          col_d   = i_ADDR[RW+CW-1:RW];
          din_d   = i_WDATA;
        end
      end
      S_RAS: state_d = S_CAS;
      S_CAS: state_d = S_ACC;
      S_ACC: state_d = S_PRE;
      S_PRE: begin
        state_d = S_IDLE;
        if (!we_q) begin
          rdata_d  = i_DRAM_DOUT;
          rvalid_d = 1'b1;
        end
      end
`ifdef DRAM_CTRL_REFRESH_EN
      S_REF_CAS: state_d = S_REF_RAS;
      S_REF_RAS: state_d = S_REF_PRE;
      S_REF_PRE: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef DRAM_CTRL_REFRESH_EN
    // A wrap always wins, so a period boundary is never lost even mid-transaction.
    if (ref_cnt_q == RCW'(REF_PERIOD - 1)) ref_pend_d = 1'b1;
    ready_d = (state_d == S_IDLE) && !ref_pend_d;
`else
    ready_d = (state_d == S_IDLE);
`endif

    // Strobes and address are decoded from the next state so they are registered.
    col_ext          = '0;
    col_ext[CW-1:0]  = col_d;
    addr_d           = addr_q;
    if (state_d == S_RAS) addr_d = i_ADDR[RW-1:0];
    else if (state_d == S_CAS || state_d == S_ACC) addr_d = col_ext;
`ifdef DRAM_CTRL_REFRESH_EN
    ras_n_d = !(state_d inside {S_RAS, S_CAS, S_ACC, S_REF_RAS});
    cas_n_d = !(state_d inside {S_CAS, S_ACC, S_REF_CAS, S_REF_RAS});
`else
    ras_n_d = !(state_d inside {S_RAS, S_CAS, S_ACC});
    cas_n_d = !(state_d inside {S_CAS, S_ACC});
`endif
    wr_n_d = !((state_d inside {S_CAS, S_ACC}) && we_d);
    rd_n_d = !((state_d inside {S_CAS, S_ACC}) && !we_d);
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      col_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      ras_n_q  <= 1'b1;
      cas_n_q  <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
`ifdef DRAM_CTRL_REFRESH_EN
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
      ras_n_q  <= ras_n_d;
      cas_n_q  <= cas_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
`ifdef DRAM_CTRL_REFRESH_EN
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
`endif
    end
  end

  assign o_READY     = ready_q;
  assign o_RDATA     = rdata_q;
  assign o_RVALID    = rvalid_q;
  assign o_DRAM_ADDR = addr_q;
  assign o_DRAM_DIN  = din_q;
  assign o_RAS_n     = ras_n_q;
  assign o_CAS_n     = cas_n_q;
  assign o_WR_n      = wr_n_q;
  assign o_RD_n      = rd_n_q;
  assign o_DBG_STATE = state_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed checks of dram_ctrl against a behavioural DRAM model.
// Refresh checks run when DRAM_CTRL_REFRESH_EN is defined; otherwise the idle-quiet check runs.
module tb_dram_ctrl;

  logic        clk;
  logic        i_RST, i_REQ, i_WE;
  logic [15:0] i_ADDR;
  logic [7:0]  i_WDATA;
  logic        o_READY, o_RVALID;
  logic [7:0]  o_RDATA, o_DRAM_ADDR, o_DRAM_DIN;
  logic [7:0]  dram_dout;
  logic        o_RAS_n, o_CAS_n, o_WR_n, o_RD_n;
  logic [2:0]  o_DBG_STATE;

  int n_checks = 0;
  int n_fail   = 0;

  logic       cap_ras [1:5], cap_cas [1:5], cap_wr [1:5], cap_rd [1:5];
  logic       cap_rvalid [1:5], cap_ready [1:5];
  logic [7:0] cap_addr [1:5], cap_din [1:5], cap_rdata [1:5];
  logic [7:0] exp_q[$];

  dram_ctrl #(.DW(8), .RW(8), .CW(8), .REF_PERIOD(16)) dut (
    .i_MCLK(clk), .i_RST(i_RST), .i_REQ(i_REQ), .i_WE(i_WE), .i_ADDR(i_ADDR),
    .i_WDATA(i_WDATA), .o_READY(o_READY), .o_RDATA(o_RDATA), .o_RVALID(o_RVALID),
    .o_DRAM_ADDR(o_DRAM_ADDR), .o_DRAM_DIN(o_DRAM_DIN), .i_DRAM_DOUT(dram_dout),
    .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_WR_n(o_WR_n), .o_RD_n(o_RD_n),
    .o_DBG_STATE(o_DBG_STATE)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural DRAM: row on RAS fall, column on CAS fall, access at end of second CAS cycle.
  logic [7:0] mem [logic [15:0]];
  logic       prev_ras = 1'b1, prev_cas = 1'b1;
  logic [7:0] row_l = 8'h00, col_l = 8'h00;
  int         cas_cnt = 0;
  initial dram_dout = 8'h00;

  always @(posedge clk) begin
    if (!o_RAS_n && prev_ras) row_l = o_DRAM_ADDR;
    if (!o_CAS_n && prev_cas) begin
      col_l   = o_DRAM_ADDR;
      cas_cnt = 1;
    end else if (!o_CAS_n) begin
      cas_cnt = cas_cnt + 1;
    end
    if (!o_CAS_n && !o_RAS_n && cas_cnt == 2) begin
      if (!o_WR_n) mem[{col_l, row_l}] = o_DRAM_DIN;
      else if (!o_RD_n) dram_dout <= mem.exists({col_l, row_l}) ? mem[{col_l, row_l}] : 8'h00;
    end
    prev_ras = o_RAS_n;
    prev_cas = o_CAS_n;
  end

  // Driver tasks
  task automatic do_reset();
    i_RST = 1'b1; i_REQ = 1'b0; i_WE = 1'b0; i_ADDR = '0; i_WDATA = '0;
    repeat (2) @(negedge clk);
    i_RST = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_READY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_READY !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready: o_READY=%b after %0d cycles, required 1", o_READY, n);
    end
  endtask

  task automatic run_access(input logic we, input logic [15:0] addr, input logic [7:0] data);
    wait_ready();
    i_REQ = 1'b1; i_WE = we; i_ADDR = addr; i_WDATA = data;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) i_REQ = 1'b0;
      cap_ras[c] = o_RAS_n; cap_cas[c] = o_CAS_n; cap_wr[c] = o_WR_n; cap_rd[c] = o_RD_n;
      cap_rvalid[c] = o_RVALID; cap_ready[c] = o_READY;
      cap_addr[c] = o_DRAM_ADDR; cap_din[c] = o_DRAM_DIN; cap_rdata[c] = o_RDATA;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_RAS_n, o_CAS_n, o_WR_n, o_RD_n} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_strobes: got %b, required 1111", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n});
    end
    n_checks++;
    if (o_READY !== 1'b1 || o_RVALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_rvalid: got %b%b, required 10", o_READY, o_RVALID);
    end
    n_checks++;
    if (o_DRAM_ADDR !== 8'h00 || o_DRAM_DIN !== 8'h00 || o_RDATA !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: addr=%h din=%h rdata=%h, required 00", o_DRAM_ADDR, o_DRAM_DIN, o_RDATA);
    end
  endtask

  task automatic test_write_read();
    logic [4:0] e_ras, e_cas, e_rd, e_wr, e_rv, e_rdy;
    run_access(1'b1, 16'h1234, 8'hA5);
    n_checks++;
    if (cap_addr[1] !== 8'h34) begin
      n_fail++; $display("FAIL wr_row_addr: got %h, required 34", cap_addr[1]);
    end
    n_checks++;
    if (cap_addr[2] !== 8'h12 || cap_addr[3] !== 8'h12) begin
      n_fail++; $display("FAIL wr_col_addr: got %h/%h, required 12/12", cap_addr[2], cap_addr[3]);
    end
    n_checks++;
    if ({cap_wr[1], cap_wr[2], cap_wr[3], cap_wr[4]} !== 4'b1001 ||
        {cap_rd[1], cap_rd[2], cap_rd[3], cap_rd[4]} !== 4'b1111) begin
      n_fail++; $display("FAIL wr_strobes: wr=%b%b%b%b rd=%b%b%b%b, required 1001/1111",
                         cap_wr[1], cap_wr[2], cap_wr[3], cap_wr[4], cap_rd[1], cap_rd[2], cap_rd[3], cap_rd[4]);
    end
    n_checks++;
    if (cap_din[1] !== 8'hA5 || cap_din[4] !== 8'hA5) begin
      n_fail++; $display("FAIL wr_din: got %h/%h, required a5", cap_din[1], cap_din[4]);
    end
    n_checks++;
    if (cap_rvalid[5] !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_rvalid: got %b, required 0", cap_rvalid[5]);
    end

    run_access(1'b0, 16'h1234, 8'h00);
    // bit c-1 holds the expected value in cycle c after acceptance
    e_ras = 5'b11000; e_cas = 5'b11001; e_rd = 5'b11001; e_wr = 5'b11111;
    e_rv  = 5'b10000; e_rdy = 5'b10000;
    for (int c = 1; c <= 5; c++) begin
      n_checks++;
      if ({cap_ras[c], cap_cas[c], cap_rd[c], cap_wr[c]} !== {e_ras[c-1], e_cas[c-1], e_rd[c-1], e_wr[c-1]}) begin
        n_fail++; $display("FAIL rd_strobes_c%0d: got ras/cas/rd/wr=%b%b%b%b, required %b%b%b%b", c,
                           cap_ras[c], cap_cas[c], cap_rd[c], cap_wr[c], e_ras[c-1], e_cas[c-1], e_rd[c-1], e_wr[c-1]);
      end
      n_checks++;
      if (cap_rvalid[c] !== e_rv[c-1] || cap_ready[c] !== e_rdy[c-1]) begin
        n_fail++; $display("FAIL rd_valid_ready_c%0d: got %b%b, required %b%b", c,
                           cap_rvalid[c], cap_ready[c], e_rv[c-1], e_rdy[c-1]);
      end
    end
    n_checks++;
    if (cap_addr[1] !== 8'h34 || cap_addr[2] !== 8'h12 || cap_addr[4] !== 8'h12) begin
      n_fail++; $display("FAIL rd_addr: got %h/%h/%h, required 34/12/12", cap_addr[1], cap_addr[2], cap_addr[4]);
    end
    n_checks++;
    if (cap_rdata[5] !== 8'hA5) begin
      n_fail++; $display("FAIL rd_data: got %h, required a5", cap_rdata[5]);
    end
    @(negedge clk);
    n_checks++;
    if (o_RVALID !== 1'b0 || o_RDATA !== 8'hA5) begin
      n_fail++; $display("FAIL rd_hold: rvalid=%b rdata=%h, required 0/a5", o_RVALID, o_RDATA);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    logic [7:0]  vals  [3];
    logic [15:0] zero_addrs [5];
    int acc_cyc [3];
    int idx, cyc;
    logic [7:0] e;
    addrs = '{16'h0001, 16'h0100, 16'hFFFF};
    vals  = '{8'h11, 8'h22, 8'h33};
    zero_addrs = '{16'h0000, 16'h0002, 16'h0101, 16'h00FF, 16'hFFFE};
    do_reset();
    wait_ready();
    idx = 0; cyc = 0;
    i_REQ = 1'b1; i_WE = 1'b1; i_ADDR = addrs[0]; i_WDATA = vals[0]; acc_cyc[0] = 0;
    acc_cyc[1] = -1; acc_cyc[2] = -1;
    while (idx < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (o_READY === 1'b1) begin
        idx++;
        if (idx < 3) begin
          i_ADDR = addrs[idx]; i_WDATA = vals[idx]; acc_cyc[idx] = cyc;
        end else begin
          i_REQ = 1'b0;
        end
      end
    end
    i_REQ = 1'b0;
    n_checks++;
    if (acc_cyc[1] !== 5 || acc_cyc[2] !== 10) begin
      n_fail++; $display("FAIL b2b_spacing: accepted at %0d/%0d, required 5/10", acc_cyc[1], acc_cyc[2]);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(vals[i]);
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, addrs[i], 8'h00);
      e = exp_q.pop_front();
      n_checks++;
      if (cap_rvalid[5] !== 1'b1 || cap_rdata[5] !== e) begin
        n_fail++; $display("FAIL b2b_read_%h: rvalid=%b rdata=%h, required 1/%h", addrs[i], cap_rvalid[5], cap_rdata[5], e);
      end
    end
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, zero_addrs[i], 8'h00);
      n_checks++;
      if (cap_rdata[5] !== 8'h00) begin
        n_fail++; $display("FAIL b2b_neighbour_%h: rdata=%h, required 00", zero_addrs[i], cap_rdata[5]);
      end
    end
  endtask

  task automatic test_reset_mid_acc();
    logic seen_rv;
    wait_ready();
    i_REQ = 1'b1; i_WE = 1'b0; i_ADDR = 16'h0001;
    @(negedge clk);
    i_REQ = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_CAS_n !== 1'b0 || o_RD_n !== 1'b0 || o_RAS_n !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_acc: ras/cas/rd=%b%b%b, required 000", o_RAS_n, o_CAS_n, o_RD_n);
    end
    i_RST = 1'b1;
    #1;
    n_checks++;
    if ({o_RAS_n, o_CAS_n, o_WR_n, o_RD_n} !== 4'b1111) begin
      n_fail++; $display("FAIL rst_async_strobes: got %b, required 1111", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n});
    end
    @(negedge clk);
    i_RST = 1'b0;
    seen_rv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_READY !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready_after: got %b, required 1", o_READY);
    end
    for (int i = 0; i < 8; i++) begin
      if (o_RVALID === 1'b1) seen_rv = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen_rv !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_rvalid: rvalid seen=%b, required 0", seen_rv);
    end
  endtask

`ifdef DRAM_CTRL_REFRESH_EN
  task automatic test_refresh();
    logic [3:0] e_cas, e_ras;
    do_reset();
    run_access(1'b1, 16'h0042, 8'h5A);   // accepted at posedge 1, now at negedge 5
    repeat (11) @(negedge clk);          // negedge 16: counter just wrapped
    n_checks++;
    if (o_READY !== 1'b0) begin
      n_fail++; $display("FAIL ref_ready_at_wrap: got %b, required 0", o_READY);
    end
    i_REQ = 1'b1; i_WE = 1'b0; i_ADDR = 16'h0042;
    // cycles 17..20: REF_CAS, REF_RAS, REF_PRE, IDLE
    e_cas = 4'b1100; e_ras = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_CAS_n !== e_cas[c] || o_RAS_n !== e_ras[c] || o_RD_n !== 1'b1 || o_WR_n !== 1'b1) begin
        n_fail++; $display("FAIL ref_seq_%0d: cas/ras/rd/wr=%b%b%b%b, required %b%b11", c,
                           o_CAS_n, o_RAS_n, o_RD_n, o_WR_n, e_cas[c], e_ras[c]);
      end
      n_checks++;
      if (o_READY !== (c == 3)) begin
        n_fail++; $display("FAIL ref_ready_%0d: got %b, required %b", c, o_READY, (c == 3));
      end
    end
    @(negedge clk);
    i_REQ = 1'b0;
    n_checks++;
    if (o_RAS_n !== 1'b0 || o_CAS_n !== 1'b1) begin
      n_fail++; $display("FAIL ref_req_accept: ras/cas=%b%b, required 01", o_RAS_n, o_CAS_n);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_RVALID !== 1'b1 || o_RDATA !== 8'h5A) begin
      n_fail++; $display("FAIL ref_readback: rvalid=%b rdata=%h, required 1/5a", o_RVALID, o_RDATA);
    end
  endtask
`else
  task automatic test_idle_quiet();
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_RAS_n, o_CAS_n, o_WR_n, o_RD_n} !== 4'b1111 || o_READY !== 1'b1) begin
        n_fail++; $display("FAIL idle_quiet_%0d: strobes=%b ready=%b, required 1111/1", i,
                           {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, o_READY);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_acc();
`ifdef DRAM_CTRL_REFRESH_EN
    test_refresh();
`else
    test_idle_quiet();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
